rs_hs_pipeline_relay_stage: RTL and testbench

- Registered relay stage placed directly downstream of the pipeline head gate.
- Its inbound port consumes the gate's FIFO-style outbound handshake and re-times it.
- Uses a 2-entry skid buffer, so data and both handshake outputs come from flops, which breaks long cross-region paths.
- Full throughput (1 word/cycle) in steady state; order preserved.

---
 rtl/rs_hs_pipeline_relay_stage.sv | 100 ++++++++++
 tb/tb_rs_hs_pipeline_relay_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_hs_pipeline_relay_stage.sv
// Registered 2-entry skid relay behind the head gate; all outputs from flops.
// Define RS_RELAY_STATS_EN to add stall_cycles / word_count counters.
module rs_hs_pipeline_relay_stage #(
  parameter int DATA_WIDTH = 32,
  parameter     __REGION   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout
`ifdef RS_RELAY_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           word_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  accept, deliver;

  assign accept  = if_write & if_full_n;
  assign deliver = if_empty_n & if_read;
  assign if_dout = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = if_din;
        end
      end
      ONE: begin
        unique case (1'b1)
          accept & ~deliver: begin
            state_d = FULL;
            skid_d  = if_din;
          end
          deliver & ~accept: state_d = EMPTY;
          accept & deliver:  main_d  = if_din;
          default: ;
        endcase
      end
      FULL: begin
        // if_full_n is low here, so only a drain can happen
        if (deliver) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      if_empty_n <= 1'b0;
      if_full_n  <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      if_empty_n <= (state_d != EMPTY);
      if_full_n  <= (state_d != FULL);
    end
  end

`ifdef RS_RELAY_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      word_count   <= '0;
    end else begin
      if (if_empty_n & ~if_read)
        stall_cycles <= stall_cycles + 32'd1;
      if (deliver)
        word_count <= word_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_hs_pipeline_relay_stage.sv
// Bench for rs_hs_pipeline_relay_stage: queue model checked every cycle
// plus directed scenarios with literal expectations.
module tb_rs_hs_pipeline_relay_stage;

  logic        clk;
  logic        reset;
  logic        if_full_n;
  logic        if_write;
  logic [31:0] if_din;
  logic        if_empty_n;
  logic        if_read;
  logic [31:0] if_dout;
`ifdef RS_RELAY_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] word_count;
`endif

  rs_hs_pipeline_relay_stage #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_full_n  (if_full_n),
    .if_write   (if_write),
    .if_din     (if_din),
    .if_empty_n (if_empty_n),
    .if_read    (if_read),
    .if_dout    (if_dout)
`ifdef RS_RELAY_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .word_count   (word_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // model: the relay is a FIFO of depth two with registered flags
  logic [31:0] q[$];
  logic        m_live = 1'b0;
  logic        m_full = 1'b0;
  logic        m_empty = 1'b0;
  logic        m_zero = 1'b1;
  logic [31:0] m_stall = '0;
  logic [31:0] m_words = '0;

  always @(posedge clk) begin
    logic acc, del;
    if (reset) begin
      q.delete();
      m_live  = 1'b1;
      m_full  = 1'b0;
      m_empty = 1'b0;
      m_zero  = 1'b1;
      m_stall = '0;
      m_words = '0;
    end else if (m_live) begin
      acc = if_write && m_full;
      del = m_empty && if_read;
      if (m_empty && !if_read) m_stall = m_stall + 32'd1;
      if (del) begin
        void'(q.pop_front());
        m_words = m_words + 32'd1;
      end
      if (acc) begin
        q.push_back(if_din);
        m_zero = 1'b0;
      end
      m_empty = (q.size() != 0);
      m_full  = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("full_n", {31'd0, if_full_n}, {31'd0, m_full});
      chk("empty_n", {31'd0, if_empty_n}, {31'd0, m_empty});
      if (m_empty) chk("dout", if_dout, q[0]);
      else if (m_zero) chk("dout_rst", if_dout, 32'd0);
`ifdef RS_RELAY_STATS_EN
      chk("stall_cycles", stall_cycles, m_stall);
      chk("word_count", word_count, m_words);
`endif
    end
  end

  // log of words the DUT hands out, for the directed checks
  logic [31:0] got[$];
  always @(negedge clk)
    if (!reset && if_empty_n === 1'b1 && if_read === 1'b1)
      got.push_back(if_dout);

  task automatic drive(input logic w, input logic [31:0] d, input logic r);
    if_write = w;
    if_din   = w ? d : 'x;
    if_read  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_got(input string nm, input logic [31:0] exp[$]);
    chk({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(nm, got[i], exp[i]);
  endtask

  initial begin
    logic [31:0] exp[$];
    int c, i, lows;
    reset = 1'b1;
    if_write = 1'b0;
    if_read = 1'b0;
    if_din = '0;

    // reset then stream
    repeat (3) drive(0, 0, 0);
    chk("rst_full_n", {31'd0, if_full_n}, 32'd0);
    chk("rst_empty_n", {31'd0, if_empty_n}, 32'd0);
    chk("rst_dout", if_dout, 32'd0);
    reset = 1'b0;
    drive(0, 0, 1);
    chk("post_rst_full_n", {31'd0, if_full_n}, 32'd1);
    got.delete();
    for (int k = 1; k <= 8; k++) begin
      drive(1, k, 1);
      chk("lat_empty_n", {31'd0, if_empty_n}, 32'd1);
      chk("lat_dout", if_dout, k);
    end
    repeat (3) drive(0, 0, 1);
    exp = '{1, 2, 3, 4, 5, 6, 7, 8};
    chk_got("stream", exp);

    // single-cycle stall
    got.delete();
    i = 0;
    c = 0;
    lows = 0;
    while (i < 16 && c < 64) begin
      logic ok;
      ok = if_full_n;
      drive(1, 32'hA0 + i, c != 8);
      if (ok) i++;
      if (!if_full_n) lows++;
      c++;
    end
    repeat (3) begin
      drive(0, 0, 1);
      if (!if_full_n) lows++;
    end
    chk("stall_lows", lows, 1);
    exp.delete();
    for (int k = 0; k < 16; k++) exp.push_back(32'hA0 + k);
    chk_got("stall", exp);

    // full hold
    got.delete();
    drive(1, 32'h11, 0);
    drive(1, 32'h22, 0);
    repeat (5) begin
      drive(1, 32'h33, 0);
      chk("hold_full_n", {31'd0, if_full_n}, 32'd0);
      chk("hold_dout", if_dout, 32'h11);
    end
    drive(1, 32'h33, 1);
    drive(1, 32'h33, 1);
    repeat (2) drive(0, 0, 1);
    exp = '{32'h11, 32'h22, 32'h33};
    chk_got("hold", exp);

    // reset mid-operation
    drive(1, 32'h55, 0);
    drive(1, 32'h66, 0);
    chk("mid_full_n", {31'd0, if_full_n}, 32'd0);
    got.delete();
    reset = 1'b1;
    drive(0, 0, 1);
    chk("mid_empty_n", {31'd0, if_empty_n}, 32'd0);
    chk("mid_dout", if_dout, 32'd0);
    reset = 1'b0;
    repeat (4) drive(0, 0, 1);
    chk("mid_none", got.size(), 0);

    // random valid/ready
    for (int k = 0; k < 10000; k++)
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    repeat (4) drive(0, 0, 1);
    chk("rand_drained", q.size(), 0);
    chk("rand_empty_n", {31'd0, if_empty_n}, 32'd0);

`ifdef RS_RELAY_STATS_EN
    reset = 1'b1;
    drive(0, 0, 0);
    reset = 1'b0;
    drive(0, 0, 0);
    drive(1, 32'h7, 0);
    repeat (4) drive(0, 0, 0);
    for (int k = 0; k < 9; k++) drive(1, 32'h100 + k, 1);
    drive(0, 0, 1);
    drive(0, 0, 1);
    chk("stats_stall", stall_cycles, 32'd4);
    chk("stats_words", word_count, 32'd10);
    drive(1, 32'h9, 0);
    force dut.word_count = 32'hFFFF_FFFF;
    m_words = 32'hFFFF_FFFF;
    #2 release dut.word_count;
    #8;
    drive(0, 0, 1);
    chk("stats_wrap", word_count, 32'd0);
    drive(0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
